// File: rtl/clk_div_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
// Optional run/stop gating is enabled by defining CLK_DIV_GATE_EN.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PEND,
    ST_STOP
  } state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered div_clk/div_tick. It also holds the active ratio.
// load_i restarts the period at 0 with ratio div_i, and hold_i parks the counter at 0 with both outputs low.
module clk_div_core #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] div_i,
  input  logic             load_i,
  input  logic             hold_i,
  output logic [CNT_W-1:0] div_o,
  output logic             boundary_o,
  output logic             div_clk_o,
  output logic             div_tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             div_clk_q, div_clk_d;
  logic             tick_q, tick_d;

  assign boundary_o = (cnt_q == div_q - 1'b1);

  // Outputs are decoded from the next count, so a register holding k shows k's phase.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    div_d     = load_i ? div_i : div_q;
    cnt_d     = cnt_q + 1'b1;
    if (hold_i || load_i || boundary_o) begin
      cnt_d = '0;
    end
    div_clk_d = !hold_i && (cnt_d < (div_d >> 1));
    tick_d    = !hold_i && (cnt_d == div_d - 1'b1);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEF_DIV);
      div_clk_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div_clk_q <= div_clk_d;
      tick_q    <= tick_d;
    end
  end

  assign div_o      = div_q;
  assign div_clk_o  = div_clk_q;
  assign div_tick_o = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: it accepts ratio changes over valid/ready and applies them only at a period boundary.
// Define CLK_DIV_GATE_EN to add the run input and the STOP state.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             div_tick,
  output logic             busy
`ifdef CLK_DIV_GATE_EN
  ,
  input  logic             run
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] pend_q;
  logic             cfg_ready_q, cfg_err_q, busy_q;

  logic             run_req, xfer, legal, accept, boundary;
  logic             core_load, core_hold;
  logic [CNT_W-1:0] core_div, active_div;

`ifdef CLK_DIV_GATE_EN
  assign run_req = run;
`else
  assign run_req = 1'b1;
`endif

  assign xfer   = cfg_valid && cfg_ready_q;
  assign legal  = (cfg_div >= CNT_W'(MIN_DIV));
  assign accept = xfer && legal;

  always_comb begin
    core_load = 1'b0;
    core_hold = 1'b0;
    core_div  = cfg_div;
    case (state_q)
      ST_RUN: begin
        if (boundary && !run_req) begin
          core_hold = 1'b1;
          core_load = accept;
        end
      end
      ST_PEND: begin
        if (boundary) begin
          core_load = 1'b1;
          core_div  = pend_q;
          core_hold = !run_req;
        end
      end
      ST_STOP: begin
        // Restart on run reloads the current ratio, so the first period begins at count 0.
        core_hold = !run_req;
        core_load = accept || run_req;
        if (!accept) begin
          core_div = active_div;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pend_q      <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cfg_err_q <= xfer && !legal;
      case (state_q)
        ST_RUN: begin
          if (boundary && !run_req) begin
            state_q     <= ST_STOP;
            cfg_ready_q <= !accept;
          end else if (accept) begin
            pend_q      <= cfg_div;
            state_q     <= ST_PEND;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end else begin
            cfg_ready_q <= 1'b1;
          end
        end
        ST_PEND: begin
          if (boundary) begin
            state_q     <= run_req ? ST_RUN : ST_STOP;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        ST_STOP: begin
          cfg_ready_q <= !accept;
          if (run_req) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  clk_div_core #(
    .CNT_W  (CNT_W),
    .DEF_DIV(DEF_DIV)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .div_i     (core_div),
    .load_i    (core_load),
    .hold_i    (core_hold),
    .div_o     (active_div),
    .boundary_o(boundary),
    .div_clk_o (div_clk),
    .div_tick_o(div_tick)
  );

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;

endmodule
